// File: rtl/bs_shift_arbiter.sv
// Round-robin arbiter that shares one barrel shifter/rotator between NREQ
// requesters. One operation is in flight at a time: the granted operand is
// registered onto the shifter inputs, the arbiter waits out the shifter
// latency, captures the result and holds it until the consumer accepts it.
module bs_shift_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int SW        = 5,
  parameter int SHIFT_LAT = 1,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ*SW-1:0]   req_sel,
  input  logic [NREQ-1:0]      req_rotate,
  output logic [DW-1:0]        bs_in,
  output logic [SW-1:0]        bs_sel,
  output logic                 bs_rotate,
  input  logic [DW-1:0]        bs_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_data,
  output logic [IDW-1:0]       rsp_id
);

  // Counter must hold SHIFT_LAT; a zero-latency shifter still needs one bit.
  localparam int CW = (SHIFT_LAT > 1) ? $clog2(SHIFT_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [CW-1:0]    cnt;

  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;

  // Round-robin search starting at ptr, wrapping at NREQ-1 (works for
  // non-power-of-two NREQ because the wrap is explicit).
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // Accept strobe is only offered while idle; the requester sees it in the
  // same cycle its valid is presented.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Control FSM plus registered shifter operands and captured response.
  // Reset clears everything, discarding any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      bs_in     <= '0;
      bs_sel    <= '0;
      bs_rotate <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            bs_in     <= req_data[int'(gnt_idx)*DW +: DW];
            bs_sel    <= req_sel[int'(gnt_idx)*SW +: SW];
            bs_rotate <= req_rotate[gnt_idx];
            rsp_id    <= gnt_idx;
            ptr       <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            cnt       <= CW'(SHIFT_LAT);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Operands stay on bs_* so a pipelined shifter sees stable inputs.
          if (cnt == '0) begin
            rsp_data  <= bs_out;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // No bypass into a new grant: the next accept is at the earliest
          // in the cycle after the response handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
